fifo_mc: RTL and testbench
==========================

# fifo_mc

Multi-channel, parametrised synchronous FIFO. It succeeds the fixed-depth shift-in delay buffer and has `CHANNELS` independent circular-buffer lanes, each with its own push/pop handshake, full/empty/count status and first-word-fall-through output. It feeds operand rows into the systolic compute array and buffers result rows back toward the CCI-P MMIO side. A global enable stalls every lane, and a synchronous clear flushes every lane.

## Interface
Parameters:
- `DEPTH`, 8: entries per lane. Must be a power of two and at least 2.
- `BITS`, 64: data width per entry.
- `CHANNELS`, 8: number of independent lanes.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  global enable; when 0, no state changes in any lane.
- `clr`  in  1  synchronous flush of all lanes; takes effect only when `en`=1.
- `push`  in  CHANNELS  per-lane write request.
- `pop`  in  CHANNELS  per-lane read request.
- `d`  in  CHANNELS*BITS  write data; lane i is bits [i*BITS +: BITS].
- `q`  out  CHANNELS*BITS  head entry of each lane; 0 when that lane is empty.
- `full`  out  CHANNELS  lane count == DEPTH.
- `empty`  out  CHANNELS  lane count == 0.
- `count`  out  CHANNELS*CNT_W  per-lane occupancy.

## Operation
- Each lane keeps `rd_ptr` and `wr_ptr` (PTR_W bits each) and `cnt` (CNT_W bits).
- Pointers wrap naturally from DEPTH-1 to 0.
- Priority per rising edge, in order:
  1. `rst_n`=0
  2. `en`=0 (hold)
  3. `clr` (pointers and counts go to 0; storage contents are not cleared)
  4. normal push/pop
- Push is accepted when `push`=1 and either the lane is not full, or it is full and `pop`=1 in the same cycle.
- An accepted push writes `d` at `wr_ptr` and increments `wr_ptr`.
- Pop is accepted when `pop`=1 and the lane is not empty. An accepted pop increments `rd_ptr`.
- `push`=1 and `pop`=1 on an empty lane: the push is accepted and the pop is ignored; count becomes 1.
- `push`=1 and `pop`=1 on a non-empty lane: both are accepted and count is unchanged.
- A push to a full lane without a pop is dropped; no pointer or count change.
- A pop on an empty lane is ignored.
- `q` is combinational from storage at `rd_ptr`, masked to 0 when the lane is empty. This is first-word-fall-through.
- Lanes never interact. Only `en`, `clr` and reset are shared.
- Arithmetic:
  - PTR_W = $clog2(DEPTH).
  - CNT_W = $clog2(DEPTH+1).
  - `cnt` never exceeds DEPTH and never underflows.

## Timing
- Reset values:
  - all pointers and counts 0
  - all storage entries 0
  - `q` = 0
  - `empty` = all 1s
  - `full` = 0
  - `count` = 0
- Latency: data pushed at edge k appears on `q` after edge k, provided the lane was empty. Write-to-read latency is 1 cycle.
- `full`, `empty` and `count` update at the same edge as the accepted push or pop.
- Reset asserted mid-operation clears state immediately and asynchronously. No partial writes occur.
- With `clr` and `push` asserted in the same cycle, `clr` wins and the push is dropped.

## Configuration
- Macro `FIFO_MC_ERR_EN`.
- When defined, the block adds outputs `ovf` (CHANNELS) and `udf` (CHANNELS):
  - `ovf` is sticky. Bit i sets at the edge where lane i drops a push.
  - `udf` is sticky. Bit i sets at the edge where lane i ignores a pop.
  - Both are cleared by reset or by an accepted `clr`.
  - Neither updates while `en`=0.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

## Structure
- Shared package `fifo_mc_pkg` holds:
  - `ptr_w(depth)` and `cnt_w(depth)` functions
  - lane status struct `fifo_status_t` (full, empty, cnt)
- Sub-module `fifo_lane`, one per channel, generated CHANNELS times.
- Top level `fifo_mc` only slices the buses and fans out `en`, `clr` and reset.

## Test plan
- Reset, then push 0x11..0x18 into lane 0 (DEPTH=8) -> `full[0]`=1, `count`=8, `q` = 0x11; all other lanes stay empty.
- Full lane 0, `push`=1 and `pop`=1 with `d`=0x19 -> `q` becomes 0x12 and `count` stays 8. Pop 8 more times -> 0x13..0x19 in order, then `empty`=1 and `q`=0.
- Push 20 entries with interleaved pops -> pointer wrap-around preserves order and `count` never exceeds 8.
- Empty lane 3, `push`=1 and `pop`=1 with 0xAB -> `count[3]`=1 and `q[3]`=0xAB. Push to a full lane with `FIFO_MC_ERR_EN` -> `ovf` bit set, data unchanged.
- `en`=0 while pushing and popping -> no change. `clr` with `push` -> all lanes empty. Assert `rst_n` mid-burst -> outputs go to reset values immediately.

Source files
------------

// File: rtl/fifo_mc_pkg.sv
// Shared sizing helpers and lane status type for the multi-channel FIFO.
// Status counts are carried at a fixed width; lanes narrow them on output.
package fifo_mc_pkg;

  localparam int CNT_MAX_W = 16;

  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef struct packed {
    logic                 full;
    logic                 empty;
    logic [CNT_MAX_W-1:0] cnt;
  } fifo_status_t;

endpackage

// File: rtl/fifo_lane.sv
// One circular-buffer FIFO lane with first-word-fall-through output.
// Optional sticky overflow/underflow flags under FIFO_MC_ERR_EN.
module fifo_lane
  import fifo_mc_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int BITS  = 64,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             push,
  input  logic             pop,
  input  logic [BITS-1:0]  d,
  output logic [BITS-1:0]  q,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
`ifdef FIFO_MC_ERR_EN
  ,
  output logic             ovf,
  output logic             udf
`endif
);

  localparam logic [CNT_MAX_W-1:0] DEPTH_C = CNT_MAX_W'(DEPTH);

  logic [BITS-1:0]      mem [DEPTH];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  fifo_status_t         st;
  logic                 do_push;
  logic                 do_pop;
  logic [CNT_MAX_W-1:0] cnt_nxt;

  // A full lane still accepts a push when a pop frees the head slot this cycle.
  assign do_pop  = pop && !st.empty;
  assign do_push = push && (!st.full || pop);
  assign cnt_nxt = st.cnt + CNT_MAX_W'(do_push) - CNT_MAX_W'(do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      st     <= '{full: 1'b0, empty: 1'b1, cnt: '0};
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (en) begin
      if (clr) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        st     <= '{full: 1'b0, empty: 1'b1, cnt: '0};
      end else begin
        if (do_push) begin
          mem[wr_ptr] <= d;
          wr_ptr      <= wr_ptr + PTR_W'(1);
        end
        if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
        st <= '{full: (cnt_nxt == DEPTH_C), empty: (cnt_nxt == '0), cnt: cnt_nxt};
      end
    end
  end

  assign q     = st.empty ? '0 : mem[rd_ptr];
  assign full  = st.full;
  assign empty = st.empty;
  assign count = st.cnt[CNT_W-1:0];

`ifdef FIFO_MC_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (en) begin
      if (clr) begin
        ovf <= 1'b0;
        udf <= 1'b0;
      end else begin
        if (push && !do_push) ovf <= 1'b1;
        if (pop && st.empty)  udf <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/fifo_mc.sv
// Multi-channel FIFO top: CHANNELS independent fifo_lane instances.
// Build with FIFO_MC_ERR_EN to expose sticky per-lane ovf/udf flags.
module fifo_mc
  import fifo_mc_pkg::*;
#(
  parameter  int DEPTH    = 8,
  parameter  int BITS     = 64,
  parameter  int CHANNELS = 8,
  localparam int CNT_W    = cnt_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic                      clr,
  input  logic [CHANNELS-1:0]       push,
  input  logic [CHANNELS-1:0]       pop,
  input  logic [CHANNELS*BITS-1:0]  d,
  output logic [CHANNELS*BITS-1:0]  q,
  output logic [CHANNELS-1:0]       full,
  output logic [CHANNELS-1:0]       empty,
  output logic [CHANNELS*CNT_W-1:0] count
`ifdef FIFO_MC_ERR_EN
  ,
  output logic [CHANNELS-1:0]       ovf,
  output logic [CHANNELS-1:0]       udf
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    fifo_lane #(
      .DEPTH (DEPTH),
      .BITS  (BITS)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .clr   (clr),
      .push  (push[i]),
      .pop   (pop[i]),
      .d     (d[i*BITS +: BITS]),
      .q     (q[i*BITS +: BITS]),
      .full  (full[i]),
      .empty (empty[i]),
      .count (count[i*CNT_W +: CNT_W])
`ifdef FIFO_MC_ERR_EN
      ,
      .ovf   (ovf[i]),
      .udf   (udf[i])
`endif
    );
  end

endmodule

// File: tb/tb_fifo_mc.sv
// Directed + short random bench for fifo_mc with a per-lane queue scoreboard.
module tb_fifo_mc;

  localparam int DEPTH = 8;
  localparam int BITS  = 64;
  localparam int CH    = 8;
  localparam int CNT_W = 4;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  en = 1'b1;
  logic                  clr = 1'b0;
  logic [CH-1:0]         push = '0;
  logic [CH-1:0]         pop = '0;
  logic [CH*BITS-1:0]    d = '0;
  logic [CH*BITS-1:0]    q;
  logic [CH-1:0]         full;
  logic [CH-1:0]         empty;
  logic [CH*CNT_W-1:0]   count;
`ifdef FIFO_MC_ERR_EN
  logic [CH-1:0]         ovf;
  logic [CH-1:0]         udf;
  logic [CH-1:0]         m_ovf = '0;
  logic [CH-1:0]         m_udf = '0;
`endif

  logic [BITS-1:0] sb [CH][$];
  int errors = 0;
  int checks = 0;

  fifo_mc #(.DEPTH(DEPTH), .BITS(BITS), .CHANNELS(CH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .d     (d),
    .q     (q),
    .full  (full),
    .empty (empty),
    .count (count)
`ifdef FIFO_MC_ERR_EN
    ,
    .ovf   (ovf),
    .udf   (udf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int lane, input logic [BITS-1:0] obs,
                       input logic [BITS-1:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s lane=%0d observed=%h expected=%h", tag, lane, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < CH; i++) begin
      int n;
      n = sb[i].size();
      check("q", i, q[i*BITS +: BITS], (n > 0) ? sb[i][0] : '0);
      check("count", i, BITS'(count[i*CNT_W +: CNT_W]), BITS'(n));
      check("full", i, BITS'(full[i]), BITS'(n == DEPTH));
      check("empty", i, BITS'(empty[i]), BITS'(n == 0));
`ifdef FIFO_MC_ERR_EN
      check("ovf", i, BITS'(ovf[i]), BITS'(m_ovf[i]));
      check("udf", i, BITS'(udf[i]), BITS'(m_udf[i]));
`endif
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) sb[i].delete();
`ifdef FIFO_MC_ERR_EN
    m_ovf = '0;
    m_udf = '0;
`endif
  endtask

  // Drive one cycle; the scoreboard pops (and compares the head) or pushes before the edge.
  task automatic step(input logic [CH-1:0] pu, input logic [CH-1:0] po,
                      input logic [BITS-1:0] dv, input logic en_v = 1'b1,
                      input logic clr_v = 1'b0);
    push = pu;
    pop  = po;
    en   = en_v;
    clr  = clr_v;
    d    = {CH{dv}};
    if (en_v && clr_v) begin
      model_reset();
    end else if (en_v) begin
      for (int i = 0; i < CH; i++) begin
        int  n;
        logic pa, wa;
        n  = sb[i].size();
        pa = po[i] && (n > 0);
        wa = pu[i] && ((n < DEPTH) || po[i]);
        if (pa) begin
          check("pop_head", i, q[i*BITS +: BITS], sb[i][0]);
          void'(sb[i].pop_front());
        end
        if (wa) sb[i].push_back(dv);
`ifdef FIFO_MC_ERR_EN
        if (pu[i] && !wa) m_ovf[i] = 1'b1;
        if (po[i] && n == 0) m_udf[i] = 1'b1;
`endif
      end
    end
    @(posedge clk);
    #1;
    push = '0;
    pop  = '0;
    en   = 1'b1;
    clr  = 1'b0;
    check_all();
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill lane 0, then a dropped push on a full lane
    for (int k = 0; k < 8; k++) step(8'h01, 8'h00, 64'h11 + 64'(k));
    step(8'h01, 8'h00, 64'h99);

    // Full lane: simultaneous push/pop, then drain and one pop past empty
    step(8'h01, 8'h01, 64'h19);
    for (int k = 0; k < 9; k++) step(8'h00, 8'h01, 64'h0);

    // Empty lane 3: push+pop together only pushes
    step(8'h08, 8'h08, 64'hAB);

    // Lane 5: 20 pushes with interleaved pops forces wrap-around and drops
    for (int k = 0; k < 20; k++) step(8'h20, (k % 3 == 1) ? 8'h20 : 8'h00, 64'h100 + 64'(k));
    for (int k = 0; k < 10; k++) step(8'h00, 8'h20, 64'h0);

    // Random traffic on all lanes
    for (int k = 0; k < 60; k++)
      step(8'($urandom), 8'($urandom), {32'($urandom), 32'($urandom)});

    // Stall: nothing may change
    step(8'hFF, 8'hFF, 64'h55, 1'b0, 1'b0);
    step(8'hFF, 8'h00, 64'h56, 1'b0, 1'b1);

    // Clear wins over push
    for (int k = 0; k < 3; k++) step(8'hFF, 8'h00, 64'h200 + 64'(k));
    step(8'hFF, 8'h00, 64'h66, 1'b1, 1'b1);
    step(8'h00, 8'hFF, 64'h0);

    // Asynchronous reset in the middle of a burst
    for (int k = 0; k < 4; k++) step(8'hFF, 8'h00, 64'h300 + 64'(k));
    push = 8'hFF;
    d    = {CH{64'h3FF}};
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    push = '0;
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h02, 8'h00, 64'h77);
    step(8'h00, 8'h02, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
